// File: rtl/inst_rom_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit. It carries the fetch-stage
// request, the virtual-ROM read handshake, the decoder-facing instruction
// stream and the sticky error flags. The fetch unit connects through the
// slave modport. The surrounding pipeline or the bench connects through the
// master modport.
interface inst_rom_fetch_unit_if;
  // fetch stage -> fetch unit
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        redirect;

  // fetch unit <-> virtual ROM
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;

  // fetch unit -> decoder
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  // sticky error flags
  logic        misaligned;
  logic        rom_timeout;

  modport slave (
    input  fetch_addr, fetch_valid, redirect, rom_ack, rom_data, inst_ready,
    output fetch_ready, rom_req, rom_addr, inst, inst_pc, inst_valid,
    output misaligned, rom_timeout
  );

  modport master (
    output fetch_addr, fetch_valid, redirect, rom_ack, rom_data, inst_ready,
    input  fetch_ready, rom_req, rom_addr, inst, inst_pc, inst_valid,
    input  misaligned, rom_timeout
  );
endinterface

// File: rtl/inst_rom_fetch_unit.sv
// Instruction fetch unit. It accepts a PC from the fetch stage and issues one
// read to the virtual ROM. The returned word and its PC go into a small FIFO
// that feeds the decoder. A redirect flushes the FIFO. If a read is still in
// flight when the redirect arrives, that read is allowed to finish, and its
// data is thrown away.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no ROM read outstanding; may accept a new fetch address
// WAIT  | ROM read outstanding; its data will be pushed into the FIFO
// DROP  | ROM read outstanding but flushed; its data will be discarded
module inst_rom_fetch_unit #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input logic                   CLK,
  input logic                   nRST,
  inst_rom_fetch_unit_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rom_addr_q;
  logic            ready_en_q;
  logic            misaligned_q;
  logic            timeout_q;

  logic [31:0]     mem_pc   [DEPTH];
  logic [31:0]     mem_data [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]   count_q;

  logic            fetch_ready;
  logic            accept;
  logic            issue;
  logic            set_mis;
  logic            set_to;
  logic            push;
  logic            pop;
  logic            inst_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ready_en_q keeps fetch_ready low while reset is held and for the edge
  // that releases it. It goes high at the first clock after release.
  assign fetch_ready = ready_en_q && (state_q == S_IDLE) && (count_q < OW'(DEPTH));
  assign accept      = bus.fetch_valid && fetch_ready;
  assign inst_valid  = (count_q != '0);
  // A redirect has priority over a pop. The flushed head entry is never
  // delivered to the decoder.
  assign pop         = inst_valid && bus.inst_ready && !bus.redirect;

  // next-state, counter and strobe decode for the fetch FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    set_mis = 1'b0;
    set_to  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.fetch_addr[1:0] != 2'b00) begin
            set_mis = 1'b1;
          end else begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.rom_ack) begin
          push    = !bus.redirect;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
        end else if (bus.redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.rom_ack) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The wait counter restarts whenever the state changes. A move from
    // WAIT to DROP therefore gives the outstanding read a fresh window.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // FSM state, wait counter, request address and sticky flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rom_addr_q   <= '0;
      ready_en_q   <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      if (issue) begin
        rom_addr_q <= bus.fetch_addr;
      end
      if (set_mis) begin
        misaligned_q <= 1'b1;
      end
      if (set_to) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // FIFO bookkeeping: pointers and occupancy; redirect empties it outright
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage. Empty slots are never shown to the decoder, so the
  // storage needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= rom_addr_q;
      mem_data[wr_ptr_q] <= bus.rom_data;
    end
  end

  assign bus.fetch_ready = fetch_ready;
  // rom_req decodes straight from the state register. Reset therefore drops
  // it at once, without waiting for a clock edge.
  assign bus.rom_req     = (state_q == S_WAIT) || (state_q == S_DROP);
  assign bus.rom_addr    = rom_addr_q;
  assign bus.inst_valid  = inst_valid;
  assign bus.inst        = inst_valid ? mem_data[rd_ptr_q] : '0;
  assign bus.inst_pc     = inst_valid ? mem_pc[rd_ptr_q]   : '0;
  assign bus.misaligned  = misaligned_q;
  assign bus.rom_timeout = timeout_q;

endmodule

// File: tb/tb_inst_rom_fetch_unit.sv
// Directed bench for inst_rom_fetch_unit. A table of per-cycle vectors covers
// the handshake, the FIFO and the redirect behaviour. Hand-written sequences
// then cover the ROM timeout and reset during an outstanding read.
module tb_inst_rom_fetch_unit;

  logic CLK;
  logic nRST;
  int   tests;
  int   fails;

  inst_rom_fetch_unit_if bus ();

  inst_rom_fetch_unit #(.DEPTH(2), .TIMEOUT(255)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] fa;
    logic        fv;
    logic        rd;
    logic        ack;
    logic [31:0] data;
    logic        ir;
    logic        e_fr;
    logic        e_req;
    logic [31:0] e_raddr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_mis;
    logic        e_to;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [31:0] fa, input logic fv, input logic rd, input logic ack,
    input logic [31:0] data, input logic ir,
    input logic e_fr, input logic e_req, input logic [31:0] e_raddr,
    input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_pc,
    input logic e_mis, input logic e_to);
    vec_t v;
    v.fa = fa; v.fv = fv; v.rd = rd; v.ack = ack; v.data = data; v.ir = ir;
    v.e_fr = e_fr; v.e_req = e_req; v.e_raddr = e_raddr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_mis = e_mis; v.e_to = e_to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] fa, input logic fv, input logic rd,
                       input logic ack, input logic [31:0] data, input logic ir);
    bus.fetch_addr  = fa;
    bus.fetch_valid = fv;
    bus.redirect    = rd;
    bus.rom_ack     = ack;
    bus.rom_data    = data;
    bus.inst_ready  = ir;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //          fa            fv rd ack data          ir  fr req raddr        iv inst          pc            mis to
    vecs[0]  = mk(32'h0,      0, 0, 0, 32'h0,         0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(32'h0,      1, 0, 0, 32'h0,         0,  0, 1, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[2]  = mk(32'h0,      0, 0, 1, 32'h20080005,  0,  1, 0, 32'h0,        1, 32'h20080005, 32'h0,        0, 0);
    vecs[3]  = mk(32'h4,      1, 0, 0, 32'h0,         0,  0, 1, 32'h4,        1, 32'h20080005, 32'h0,        0, 0);
    vecs[4]  = mk(32'h0,      0, 0, 1, 32'h11111111,  0,  0, 0, 32'h0,        1, 32'h20080005, 32'h0,        0, 0);
    vecs[5]  = mk(32'h8,      1, 0, 0, 32'h0,         0,  0, 0, 32'h0,        1, 32'h20080005, 32'h0,        0, 0);
    vecs[6]  = mk(32'h0,      0, 0, 0, 32'h0,         1,  1, 0, 32'h0,        1, 32'h11111111, 32'h4,        0, 0);
    vecs[7]  = mk(32'h0,      0, 0, 0, 32'h0,         1,  1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[8]  = mk(32'h8,      1, 0, 0, 32'h0,         0,  0, 1, 32'h8,        0, 32'h0,        32'h0,        0, 0);
    vecs[9]  = mk(32'h0,      0, 1, 0, 32'h0,         0,  0, 1, 32'h8,        0, 32'h0,        32'h0,        0, 0);
    vecs[10] = mk(32'h0,      0, 0, 1, 32'hDEADBEEF,  0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[11] = mk(32'h0,      0, 0, 0, 32'h0,         0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[12] = mk(32'hC,      1, 0, 0, 32'h0,         0,  0, 1, 32'hC,        0, 32'h0,        32'h0,        0, 0);
    vecs[13] = mk(32'h0,      0, 1, 1, 32'h12345678,  0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[14] = mk(32'h20,     1, 0, 0, 32'h0,         0,  0, 1, 32'h20,       0, 32'h0,        32'h0,        0, 0);
    vecs[15] = mk(32'h0,      0, 0, 1, 32'hA0A0A0A0,  0,  1, 0, 32'h0,        1, 32'hA0A0A0A0, 32'h20,       0, 0);
    vecs[16] = mk(32'h24,     1, 0, 0, 32'h0,         0,  0, 1, 32'h24,       1, 32'hA0A0A0A0, 32'h20,       0, 0);
    vecs[17] = mk(32'h0,      0, 0, 1, 32'hB1B1B1B1,  1,  1, 0, 32'h0,        1, 32'hB1B1B1B1, 32'h24,       0, 0);
    vecs[18] = mk(32'h40,     1, 1, 0, 32'h0,         1,  0, 1, 32'h40,       0, 32'h0,        32'h0,        0, 0);
    vecs[19] = mk(32'h0,      0, 0, 1, 32'h40404040,  0,  1, 0, 32'h0,        1, 32'h40404040, 32'h40,       0, 0);
    vecs[20] = mk(32'h0,      0, 1, 0, 32'h0,         1,  1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[21] = mk(32'h6,      1, 0, 0, 32'h0,         0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[22] = mk(32'h0,      0, 0, 0, 32'h0,         0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[23] = mk(32'h50,     1, 0, 0, 32'h0,         0,  0, 1, 32'h50,       0, 32'h0,        32'h0,        1, 0);
    vecs[24] = mk(32'h0,      0, 0, 1, 32'h50505050,  0,  1, 0, 32'h0,        1, 32'h50505050, 32'h50,       1, 0);

    // reset state
    drive(32'h0, 0, 0, 0, 32'h0, 0);
    nRST = 1'b0;
    tick();
    tick();
    chk("reset fetch_ready", {31'b0, bus.fetch_ready}, 32'h0);
    chk("reset rom_req",     {31'b0, bus.rom_req},     32'h0);
    chk("reset rom_addr",    bus.rom_addr,             32'h0);
    chk("reset inst_valid",  {31'b0, bus.inst_valid},  32'h0);
    chk("reset inst",        bus.inst,                 32'h0);
    chk("reset inst_pc",     bus.inst_pc,              32'h0);
    chk("reset misaligned",  {31'b0, bus.misaligned},  32'h0);
    chk("reset rom_timeout", {31'b0, bus.rom_timeout}, 32'h0);
    nRST = 1'b1;

    // per-cycle vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fa, vecs[i].fv, vecs[i].rd, vecs[i].ack, vecs[i].data, vecs[i].ir);
      tick();
      chk($sformatf("v%0d fetch_ready", i), {31'b0, bus.fetch_ready}, {31'b0, vecs[i].e_fr});
      chk($sformatf("v%0d rom_req", i),     {31'b0, bus.rom_req},     {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d inst_valid", i),  {31'b0, bus.inst_valid},  {31'b0, vecs[i].e_iv});
      chk($sformatf("v%0d inst", i),        bus.inst,                 vecs[i].e_inst);
      chk($sformatf("v%0d inst_pc", i),     bus.inst_pc,              vecs[i].e_pc);
      chk($sformatf("v%0d misaligned", i),  {31'b0, bus.misaligned},  {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d rom_timeout", i), {31'b0, bus.rom_timeout}, {31'b0, vecs[i].e_to});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d rom_addr", i), bus.rom_addr, vecs[i].e_raddr);
      end
    end

    // ROM timeout: one buffered entry (pc 0x50) is still held
    drive(32'h10, 1, 0, 0, 32'h0, 0);
    tick();
    drive(32'h0, 0, 0, 0, 32'h0, 0);
    chk("to accept rom_req", {31'b0, bus.rom_req}, 32'h1);
    for (int k = 0; k < 254; k++) tick();
    chk("to 254 rom_req",     {31'b0, bus.rom_req},     32'h1);
    chk("to 254 rom_addr",    bus.rom_addr,             32'h10);
    chk("to 254 rom_timeout", {31'b0, bus.rom_timeout}, 32'h0);
    tick();
    chk("to 255 rom_timeout", {31'b0, bus.rom_timeout}, 32'h1);
    chk("to 255 rom_req",     {31'b0, bus.rom_req},     32'h0);
    chk("to 255 fetch_ready", {31'b0, bus.fetch_ready}, 32'h1);
    chk("to 255 inst",        bus.inst,                 32'h50505050);
    tick();
    chk("to sticky",          {31'b0, bus.rom_timeout}, 32'h1);

    // reset during WAIT, then a late ack after release
    drive(32'h30, 1, 0, 0, 32'h0, 0);
    tick();
    drive(32'h0, 0, 0, 0, 32'h0, 0);
    chk("rst wait rom_req", {31'b0, bus.rom_req}, 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst async rom_req",     {31'b0, bus.rom_req},     32'h0);
    chk("rst async fetch_ready", {31'b0, bus.fetch_ready}, 32'h0);
    chk("rst async inst_valid",  {31'b0, bus.inst_valid},  32'h0);
    chk("rst async misaligned",  {31'b0, bus.misaligned},  32'h0);
    chk("rst async rom_timeout", {31'b0, bus.rom_timeout}, 32'h0);
    tick();
    nRST = 1'b1;
    drive(32'h0, 0, 0, 1, 32'h99999999, 0);
    chk("rst release fetch_ready", {31'b0, bus.fetch_ready}, 32'h0);
    tick();
    chk("post rst fetch_ready", {31'b0, bus.fetch_ready}, 32'h1);
    chk("post rst inst_valid",  {31'b0, bus.inst_valid},  32'h0);
    chk("post rst rom_req",     {31'b0, bus.rom_req},     32'h0);
    tick();
    chk("late ack inst_valid",  {31'b0, bus.inst_valid},  32'h0);
    chk("late ack inst",        bus.inst,                 32'h0);
    drive(32'h0, 0, 0, 0, 32'h0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
